posit_arith_top: RTL and testbench

Pipelined posit adder/subtractor for `posit_width`-bit posits with `es` exponent bits (default posit⟨8,1⟩). Each cycle it accepts two operands and an opcode. Four cycles later it returns the correctly rounded posit sum or difference, plus `done` and `zero` flags. It is the arithmetic top level that sits between operand registers and the result write-back path, with a fully pipelined throughput of one operation per clock.

---
 rtl/posit_arith_top.sv | 235 +++++++++++++++++++++++
 tb/tb_posit_arith_top.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_arith_top.sv
// Pipelined posit adder/subtractor, latency 4, one operation per clock.
// Input register, then decode, align, add/normalize, encode/round stages.
module posit_arith_top #(
  parameter int posit_width = 8,
  parameter int es = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             opcode,
  input  logic [posit_width-1:0] a,
  input  logic [posit_width-1:0] b,
  output logic                   done,
  output logic                   zero,
  output logic [posit_width-1:0] result
);

  localparam int N  = posit_width;
  localparam int F  = N - 1;
  localparam int EW = (es > 0) ? es : 1;
  localparam int W  = N + 3;
  localparam int SW = 12;
  localparam int FW = 1 + EW + W + N;
  localparam logic [N-1:0] NAR = {1'b1, {F{1'b0}}};
  localparam logic signed [SW-1:0] KMAX = SW'(N - 2);

  typedef struct packed {
    logic          sgn;
    logic [SW-1:0] scl;
    logic [N-1:0]  man;
  } dec_t;

  function automatic dec_t decode(input logic [N-1:0] p);
    dec_t d;
    logic [F-1:0] rem;
    logic [F-1:0] sh;
    logic [EW-1:0] ex;
    logic [SW-1:0] k;
    logic run;
    int m;
    rem = F'(p[N-1] ? -p : p);
    m = 0;
    run = 1'b1;
    for (int i = F - 1; i >= 0; i--) begin
      if (run && rem[i] == rem[F-1]) m = m + 1;
      else run = 1'b0;
    end
    sh = rem << (m + 1);
    ex = sh[F-1 -: EW] >> (EW - es);
    k = rem[F-1] ? SW'(m - 1) : SW'(-m);
    d.sgn = p[N-1];
    d.scl = (k << es) + SW'(ex);
    d.man = {1'b1, F'(sh << es)};
    return d;
  endfunction

  logic          p0_v;
  logic [1:0]    p0_op;
  logic [N-1:0]  p0_a;
  logic [N-1:0]  p0_b;

  logic          p1_v;
  logic          p1_spec;
  logic [N-1:0]  p1_val;
  dec_t          p1_a;
  dec_t          p1_b;

  logic          p2_v;
  logic          p2_spec;
  logic [N-1:0]  p2_val;
  logic          p2_sgn;
  logic          p2_sub;
  logic [SW-1:0] p2_scl;
  logic [W-1:0]  p2_ml;
  logic [W-1:0]  p2_ms;

  logic          p3_v;
  logic          p3_spec;
  logic [N-1:0]  p3_val;
  logic          p3_sgn;
  logic          p3_zero;
  logic [SW-1:0] p3_scl;
  logic [W-1:0]  p3_fr;

  // decode
  logic [N-1:0] b_eff;
  logic         bad;
  logic         s1_spec;
  logic [N-1:0] s1_val;

  assign b_eff = (p0_op == 2'b01) ? -p0_b : p0_b;
  assign bad = p0_op[1] | (p0_a == NAR) | (b_eff == NAR);
  assign s1_spec = bad | (p0_a == '0) | (b_eff == '0);
  assign s1_val = bad ? NAR : ((p0_a == '0) ? b_eff : p0_a);

  // compare/swap and align
  dec_t          lg;
  dec_t          sm;
  logic          swap;
  logic [SW-1:0] dif;
  logic [2*W-1:0] ext;
  logic [W-1:0]  al;
  logic          stk;

  always_comb begin
    swap = ($signed(p1_b.scl) > $signed(p1_a.scl)) ||
           (p1_b.scl == p1_a.scl && p1_b.man > p1_a.man);
    lg = swap ? p1_b : p1_a;
    sm = swap ? p1_a : p1_b;
    dif = lg.scl - sm.scl;
    ext = {sm.man, 3'b000, {W{1'b0}}} >> dif;
    al = ext[2*W-1 -: W];
    stk = |ext[W-1:0];
    if (dif >= SW'(W)) begin
      al = '0;
      stk = 1'b1;
    end
  end

  // add/sub and normalize
  logic [W:0]    sum;
  logic [SW-1:0] lz;
  logic          found;
  logic [SW-1:0] scl3;
  logic [W-1:0]  fr3;

  always_comb begin
    sum = p2_sub ? ({1'b0, p2_ml} - {1'b0, p2_ms})
                 : ({1'b0, p2_ml} + {1'b0, p2_ms});
    lz = '0;
    found = 1'b0;
    for (int i = W; i >= 0; i--) begin
      if (!found && sum[i]) begin
        found = 1'b1;
        lz = SW'(W - i);
      end
    end
    fr3 = W'(sum << lz);
    scl3 = p2_scl + SW'(1) - lz;
  end

  // encode and round on the bit pattern
  logic signed [SW-1:0] k4;
  logic [EW-1:0]  e4;
  logic           term;
  logic [SW-1:0]  rs;
  logic [EW+W-1:0] tail;
  logic [FW-1:0]  vv;
  logic [F-1:0]   pat;
  logic [F-1:0]   pr;
  logic           g;
  logic           st;
  logic [N-1:0]   mag;
  logic [N-1:0]   res_n;

  always_comb begin
    k4 = $signed(p3_scl) >>> es;
    e4 = EW'(p3_scl) & EW'((1 << es) - 1);
    term = k4[SW-1];
    rs = term ? -k4 : k4 + SW'(1);
    tail = {e4, p3_fr} << (EW - es);
    vv = {term, tail, {N{1'b0}}} >> rs;
    if (!term) vv = vv | ~({FW{1'b1}} >> rs);
    pat = vv[FW-1 -: F];
    g = vv[FW-1-F];
    st = |vv[FW-2-F:0];
    pr = pat + F'(g & (pat[0] | st));
    if (p3_zero) mag = '0;
    else if (k4 >= KMAX) mag = {1'b0, {F{1'b1}}};
    else if (k4 < -KMAX) mag = N'(1);
    else mag = {1'b0, pr};
    res_n = p3_spec ? p3_val : (p3_sgn ? -mag : mag);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p0_v <= 1'b0;
      p0_op <= '0;
      p0_a <= '0;
      p0_b <= '0;
      p1_v <= 1'b0;
      p1_spec <= 1'b0;
      p1_val <= '0;
      p1_a <= '0;
      p1_b <= '0;
      p2_v <= 1'b0;
      p2_spec <= 1'b0;
      p2_val <= '0;
      p2_sgn <= 1'b0;
      p2_sub <= 1'b0;
      p2_scl <= '0;
      p2_ml <= '0;
      p2_ms <= '0;
      p3_v <= 1'b0;
      p3_spec <= 1'b0;
      p3_val <= '0;
      p3_sgn <= 1'b0;
      p3_zero <= 1'b0;
      p3_scl <= '0;
      p3_fr <= '0;
      done <= 1'b0;
      zero <= 1'b0;
      result <= '0;
    end else begin
      p0_v <= start;
      p0_op <= opcode;
      p0_a <= a;
      p0_b <= b;
      p1_v <= p0_v;
      p1_spec <= s1_spec;
      p1_val <= s1_val;
      p1_a <= decode(p0_a);
      p1_b <= decode(b_eff);
      p2_v <= p1_v;
      p2_spec <= p1_spec;
      p2_val <= p1_val;
      p2_sgn <= lg.sgn;
      p2_sub <= lg.sgn ^ sm.sgn;
      p2_scl <= lg.scl;
      p2_ml <= {lg.man, 3'b000};
      p2_ms <= al | W'(stk);
      p3_v <= p2_v;
      p3_spec <= p2_spec;
      p3_val <= p2_val;
      p3_sgn <= p2_sgn;
      p3_zero <= (sum == '0);
      p3_scl <= scl3;
      p3_fr <= fr3;
      done <= p3_v;
      zero <= (res_n == '0);
      result <= res_n;
    end
  end

endmodule

// File: tb/tb_posit_arith_top.sv
// Bench for posit_arith_top (posit<8,1>): directed cases plus a random
// stream checked against a value-level reference model.
module tb_posit_arith_top;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       done;
  logic       zero;
  logic [7:0] result;

  int checks = 0;
  int passed = 0;

  posit_arith_top #(.posit_width(8), .es(1)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .opcode(opcode),
    .a(a),
    .b(b),
    .done(done),
    .zero(zero),
    .result(result)
  );

  always #5 clk = ~clk;

  // value of a posit<n,1> pattern in units of 2^-16
  function automatic longint pval(input int n, input int pin);
    int p, v, i, m, k, e, fb, r0, sh;
    longint val;
    p = pin & ((1 << n) - 1);
    if (p == 0 || p == (1 << (n - 1))) return 0;
    v = ((p >> (n - 1)) != 0) ? (1 << n) - p : p;
    r0 = (v >> (n - 2)) & 1;
    i = n - 2;
    m = 0;
    while (i >= 0 && ((v >> i) & 1) == r0) begin
      m++;
      i--;
    end
    if (i >= 0) i--;
    k = (r0 == 1) ? m - 1 : -m;
    e = 0;
    if (i >= 0) begin
      e = (v >> i) & 1;
      i--;
    end
    fb = i + 1;
    val = (longint'(1) << fb) + longint'(v & ((1 << fb) - 1));
    sh = 2 * k + e + 16 - fb;
    val = (sh >= 0) ? (val <<< sh) : (val >>> (-sh));
    return ((p >> (n - 1)) != 0) ? -val : val;
  endfunction

  function automatic logic [7:0] ref_add(input logic [7:0] x, input logic [7:0] y,
                                         input logic [1:0] op);
    logic [7:0] bb;
    logic [7:0] r;
    longint s, mg, mid;
    if (op[1]) return 8'h80;
    bb = op[0] ? -y : y;
    if (x == 8'h80 || bb == 8'h80) return 8'h80;
    s = pval(8, int'(x)) + pval(8, int'(bb));
    if (s == 0) return 8'h00;
    mg = (s < 0) ? -s : s;
    r = 8'h01;
    if (mg >= pval(8, 127)) r = 8'h7F;
    else if (mg <= pval(8, 1)) r = 8'h01;
    else begin
      for (int p = 1; p < 127; p++) begin
        if (pval(8, p) <= mg && mg < pval(8, p + 1)) begin
          mid = pval(9, 2 * p + 1);
          if (mg > mid) r = 8'(p + 1);
          else if (mg < mid) r = 8'(p);
          else r = ((p % 2) == 1) ? 8'(p + 1) : 8'(p);
        end
      end
    end
    return (s < 0) ? -r : r;
  endfunction

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop,
                       output logic [7:0] r, output logic z, output logic d_early,
                       output logic d);
    @(negedge clk);
    a = ia;
    b = ib;
    opcode = iop;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 d_early = done;
    @(posedge clk);
    #1;
    r = result;
    z = zero;
    d = done;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (result !== 8'h00) $display("FAIL reset_result got %h want 00", result);
    else passed++;
    checks++;
    if (zero !== 1'b0) $display("FAIL reset_zero got %b want 0", zero);
    else passed++;
    checks++;
    if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add;
    logic [7:0] r;
    logic z, de, d;
    issue(8'h40, 8'h40, 2'b00, r, z, de, d);
    checks++;
    if ({de, d, z, r} !== {1'b0, 1'b1, 1'b0, 8'h50})
      $display("FAIL add_1p1 got early=%b done=%b zero=%b res=%h want 0/1/0/50", de, d, z, r);
    else passed++;
    issue(8'h40, 8'h50, 2'b00, r, z, de, d);
    checks++;
    if ({de, d, z, r} !== {1'b0, 1'b1, 1'b0, 8'h58})
      $display("FAIL add_1p2 got early=%b done=%b zero=%b res=%h want 0/1/0/58", de, d, z, r);
    else passed++;
  endtask

  task automatic test_sub;
    logic [7:0] r;
    logic z, de, d;
    issue(8'h40, 8'h40, 2'b01, r, z, de, d);
    checks++;
    if ({d, z, r} !== {1'b1, 1'b1, 8'h00})
      $display("FAIL sub_1m1 got done=%b zero=%b res=%h want 1/1/00", d, z, r);
    else passed++;
    issue(8'h40, 8'h50, 2'b01, r, z, de, d);
    checks++;
    if ({d, z, r} !== {1'b1, 1'b0, 8'hC0})
      $display("FAIL sub_1m2 got done=%b zero=%b res=%h want 1/0/c0", d, z, r);
    else passed++;
  endtask

  task automatic test_specials;
    logic [7:0] r;
    logic z, de, d;
    logic [7:0] ta [5] = '{8'h80, 8'h00, 8'h7F, 8'h01, 8'h81};
    logic [7:0] tb [5] = '{8'h40, 8'h58, 8'h7F, 8'h00, 8'h81};
    logic [1:0] to [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [7:0] te [5] = '{8'h80, 8'h58, 8'h7F, 8'h01, 8'h81};
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], to[i], r, z, de, d);
      checks++;
      if ({d, z, r} !== {1'b1, 1'b0, te[i]})
        $display("FAIL special_%0d got done=%b zero=%b res=%h want 1/0/%h", i, d, z, r, te[i]);
      else passed++;
    end
  endtask

  task automatic test_ties;
    logic [7:0] r;
    logic z, de, d;
    issue(8'h40, 8'h0C, 2'b00, r, z, de, d);
    checks++;
    if (r !== 8'h40) $display("FAIL tie_down got %h want 40", r);
    else passed++;
    issue(8'h41, 8'h0C, 2'b00, r, z, de, d);
    checks++;
    if (r !== 8'h42) $display("FAIL tie_up got %h want 42", r);
    else passed++;
  endtask

  task automatic test_reserved;
    logic [7:0] r;
    logic z, de, d;
    issue(8'h40, 8'h40, 2'b10, r, z, de, d);
    checks++;
    if ({d, z, r} !== {1'b1, 1'b0, 8'h80})
      $display("FAIL reserved_10 got done=%b zero=%b res=%h want 1/0/80", d, z, r);
    else passed++;
    issue(8'h00, 8'h00, 2'b11, r, z, de, d);
    checks++;
    if ({d, z, r} !== {1'b1, 1'b0, 8'h80})
      $display("FAIL reserved_11 got done=%b zero=%b res=%h want 1/0/80", d, z, r);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int idx;
    idx = 0;
    for (int c = 0; c < 505; c++) begin
      @(negedge clk);
      if (c >= 5) begin
        e = exp_q.pop_front();
        checks++;
        if ({done, zero, result} !== {1'b1, e == 8'h00, e})
          $display("FAIL stream_%0d got done=%b zero=%b res=%h want 1/%b/%h",
                   idx, done, zero, result, e == 8'h00, e);
        else passed++;
        idx++;
      end
      if (c < 500) begin
        a = 8'($urandom);
        b = 8'($urandom);
        opcode = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(2, 3))
                                              : 2'($urandom_range(0, 1));
        start = 1'b1;
        exp_q.push_back(ref_add(a, b, opcode));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL stream_drain got done=%b want 0", done);
    else passed++;
  endtask

  task automatic test_reset_mid;
    logic seen;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'h40;
      b = 8'h40;
      opcode = 2'b00;
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, result} !== {1'b1, 8'h50})
      $display("FAIL pre_reset got done=%b res=%h want 1/50", done, result);
    else passed++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({done, zero, result} !== {1'b0, 1'b0, 8'h00})
      $display("FAIL mid_reset got done=%b zero=%b res=%h want 0/0/00", done, zero, result);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 if (done) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL stale_done got %b want 0", seen);
    else passed++;
  endtask

  task automatic test_resume;
    logic [7:0] r;
    logic z, de, d;
    issue(8'h50, 8'h40, 2'b00, r, z, de, d);
    checks++;
    if ({de, d, r} !== {1'b0, 1'b1, 8'h58})
      $display("FAIL resume got early=%b done=%b res=%h want 0/1/58", de, d, r);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_specials();
    test_ties();
    test_reserved();
    test_back_to_back();
    test_reset_mid();
    test_resume();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
